// File: rtl/glb_hs.sv
// -----------------------------------------------------------------------------
// glb_hs -- single-port word store with valid/ready request and response
// channels and a hardware zeroing sweep.
//
// A request (read or write) is accepted on an edge where w_req_valid and
// r_req_ready are both high. Writes return nothing; reads load a single-entry
// response register that is presented one cycle later and held until the
// consumer takes it with w_rsp_ready. Pulsing w_clear (or releasing reset)
// runs a DEPTH-cycle sweep that writes zero to every word while r_busy is high.
//
// Optional feature macro: GLB_ERR_EN -- adds the sticky r_err output, set when
// an out-of-range request is accepted and cleared by reset or a new sweep.
//
// Ports:
//   w_clk        in   clock, rising edge
//   w_rst_n      in   asynchronous active-low reset
//   w_req_valid  in   request present
//   r_req_ready  out  request can be accepted this cycle
//   w_req_rw     in   1 = write, 0 = read
//   w_req_addr   in   word address [ADDR_W]
//   w_req_data   in   write data [DATA_W]
//   r_rsp_valid  out  read response present
//   w_rsp_ready  in   consumer takes the response
//   r_rsp_data   out  read data [DATA_W]
//   w_clear      in   start a zeroing sweep
//   r_busy       out  sweep in progress
//   r_err        out  sticky out-of-range flag (GLB_ERR_EN only)
// -----------------------------------------------------------------------------
module glb_hs #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_req_valid,
    output logic              r_req_ready,
    input  logic              w_req_rw,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              r_rsp_valid,
    input  logic              w_rsp_ready,
    output logic [DATA_W-1:0] r_rsp_data,
    input  logic              w_clear,
    output logic              r_busy
`ifdef GLB_ERR_EN
    ,
    output logic              r_err
`endif
);

    // Index width for the storage array; the address compare is done one bit
    // wider so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_CMP = CMP_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    // Reject illegal configurations at elaboration.
    if ((DEPTH < 2) || (DEPTH > 1024) || ((64'(1) << ADDR_W) < 64'(DEPTH))) begin : g_param_chk
        $error("glb_hs: DEPTH must be 2..1024 and fit in ADDR_W address bits");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef GLB_ERR_EN
    logic              err_q, err_d;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_ready_c;
    logic              accept_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;
    logic              mem_we_c;
    logic [IDX_W-1:0]  mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Request decode: ready also depends on the response slot draining this edge.
    always_comb begin
        req_ready_c = (state_q == ST_IDLE) && !w_clear && (!rsp_valid_q || w_rsp_ready);
        accept_c    = w_req_valid && req_ready_c;
        in_range_c  = ({1'b0, w_req_addr} < DEPTH_CMP);
        idx_c       = w_req_addr[IDX_W-1:0];
    end

    // Next-state, storage write port and response register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
`ifdef GLB_ERR_EN
        err_d       = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
`ifdef GLB_ERR_EN
                    err_d   = 1'b0;
`endif
                end else if (accept_c && w_req_rw && in_range_c) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = idx_c;
                    mem_wdata_c = w_req_data;
                end
            end
            ST_CLEAR: begin
                // One word zeroed per edge; the last word returns to IDLE.
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q;
                mem_wdata_c = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase

        // A new read may refill the slot on the same edge the old one drains.
        if (accept_c && !w_req_rw) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = in_range_c ? mem[idx_c] : '0;
        end else if (w_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

`ifdef GLB_ERR_EN
        if (accept_c && !in_range_c) begin
            err_d = 1'b1;
        end
`endif
    end

    // Control state; reset lands in CLEAR so the array is swept after release.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef GLB_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef GLB_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Storage array; contents are defined by the sweep, not by reset.
    always_ff @(posedge w_clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign r_req_ready = req_ready_c;
    assign r_rsp_valid = rsp_valid_q;
    assign r_rsp_data  = rsp_data_q;
    assign r_busy      = (state_q == ST_CLEAR);
`ifdef GLB_ERR_EN
    assign r_err       = err_q;
`endif

endmodule

// File: tb/tb_glb_hs.sv
// -----------------------------------------------------------------------------
// tb_glb_hs -- scoreboard bench for glb_hs. A behavioural model tracks the
// word array, sweep length and response slot; expected read data is queued at
// acceptance and a separate monitor compares whatever the DUT presents.
// ADDR_W is one bit wider than needed so out-of-range addresses are reachable.
// -----------------------------------------------------------------------------
module tb_glb_hs;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 7;

    logic              w_clk;
    logic              w_rst_n;
    logic              w_req_valid;
    logic              r_req_ready;
    logic              w_req_rw;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic              r_rsp_valid;
    logic              w_rsp_ready;
    logic [DATA_W-1:0] r_rsp_data;
    logic              w_clear;
    logic              r_busy;
`ifdef GLB_ERR_EN
    logic              r_err;
`endif

    glb_hs #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_req_valid (w_req_valid),
        .r_req_ready (r_req_ready),
        .w_req_rw    (w_req_rw),
        .w_req_addr  (w_req_addr),
        .w_req_data  (w_req_data),
        .r_rsp_valid (r_rsp_valid),
        .w_rsp_ready (w_rsp_ready),
        .r_rsp_data  (r_rsp_data),
        .w_clear     (w_clear),
        .r_busy      (r_busy)
`ifdef GLB_ERR_EN
        ,
        .r_err       (r_err)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_mem[DEPTH];
    int                busy_left;
    bit                m_rsp_valid;
    bit                m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    endtask

    // Reference model: decides at the falling edge what the next rising edge does.
    initial begin : model
        bit                in_rst, busy, exp_ready, acc;
        bit                v, rw, rr, clr;
        int                addr;
        logic [DATA_W-1:0] data;
        busy_left   = int'(DEPTH);
        m_rsp_valid = 1'b0;
        m_err       = 1'b0;
        zero_model();
        forever begin
            @(negedge w_clk);
            in_rst    = !w_rst_n;
            busy      = (busy_left > 0);
            exp_ready = !in_rst && !busy && !w_clear && (!m_rsp_valid || w_rsp_ready);
            check("busy", 32'(r_busy), in_rst ? 32'd1 : 32'(busy));
            check("req_ready", 32'(r_req_ready), 32'(exp_ready));
`ifdef GLB_ERR_EN
            check("err", 32'(r_err), in_rst ? 32'd0 : 32'(m_err));
`endif
            v    = w_req_valid;
            rw   = w_req_rw;
            addr = int'(w_req_addr);
            data = w_req_data;
            rr   = w_rsp_ready;
            clr  = w_clear;
            acc  = v && exp_ready;

            @(posedge w_clk);
            #2;
            if (in_rst) begin
                busy_left   = int'(DEPTH);
                m_rsp_valid = 1'b0;
                m_err       = 1'b0;
                exp_q.delete();
                zero_model();
            end else begin
                if (busy) begin
                    busy_left--;
                end else if (clr) begin
                    busy_left = int'(DEPTH);
                    m_err     = 1'b0;
                    zero_model();
                end else if (acc) begin
                    if (addr >= int'(DEPTH)) m_err = 1'b1;
                    if (rw) begin
                        if (addr < int'(DEPTH)) m_mem[addr] = data;
                    end else begin
                        exp_q.push_back((addr < int'(DEPTH)) ? m_mem[addr] : '0);
                    end
                end
                if (acc && !rw)  m_rsp_valid = 1'b1;
                else if (rr)     m_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: compares the presented response against the queue head.
    initial begin : monitor
        forever begin
            @(negedge w_clk);
            if (!w_rst_n) begin
                check("rst_rsp_valid", 32'(r_rsp_valid), 32'd0);
                check("rst_rsp_data", 32'(r_rsp_data), 32'd0);
            end else begin
                check("rsp_valid", 32'(r_rsp_valid), 32'(exp_q.size() != 0));
                if (r_rsp_valid && exp_q.size() != 0) begin
                    check("rsp_data", 32'(r_rsp_data), 32'(exp_q[0]));
                    if (w_rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit v, input bit rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit rr, input bit clr);
        @(posedge w_clk);
        #1;
        w_req_valid = v;
        w_req_rw    = rw;
        w_req_addr  = a;
        w_req_data  = d;
        w_rsp_ready = rr;
        w_clear     = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin : stim
        int                sel;
        logic [ADDR_W-1:0] ra;
        w_rst_n     = 1'b0;
        w_req_valid = 1'b0;
        w_req_rw    = 1'b0;
        w_req_addr  = '0;
        w_req_data  = '0;
        w_rsp_ready = 1'b0;
        w_clear     = 1'b0;

        // Reset release, full sweep, then a read of a swept word.
        repeat (3) @(posedge w_clk);
        #1 w_rst_n = 1'b1;
        idle(int'(DEPTH) + 2);
        drive(1, 0, 7'd5, '0, 1, 0);
        idle(2);

        // Write then read back.
        drive(1, 1, 7'd10, 16'hBEEF, 1, 0);
        drive(1, 0, 7'd10, '0, 1, 0);
        idle(2);

        // Backpressure: held response, refused requests, then back-to-back.
        drive(1, 0, 7'd10, '0, 0, 0);
        repeat (5) drive(1, 0, 7'd7, '0, 0, 0);
        drive(1, 0, 7'd3, '0, 1, 0);
        idle(3);

        // Clear beats a simultaneous request.
        drive(1, 1, 7'd63, 16'h1234, 1, 0);
        drive(1, 1, 7'd5, 16'h5555, 1, 1);
        idle(int'(DEPTH) + 1);
        drive(1, 0, 7'd63, '0, 1, 0);
        drive(1, 0, 7'd5, '0, 1, 0);
        idle(2);

        // Out-of-range write and read, then a sweep clears the error flag.
        drive(1, 1, 7'd100, 16'hAAAA, 1, 0);
        drive(1, 0, 7'd100, '0, 1, 0);
        idle(3);
        drive(0, 0, '0, '0, 1, 1);
        idle(int'(DEPTH) + 1);

        // Mid-sweep reset with a response pending.
        drive(1, 1, 7'd20, 16'h7777, 1, 0);
        drive(1, 0, 7'd20, '0, 0, 0);
        drive(0, 0, '0, '0, 0, 1);
        repeat (20) drive(0, 0, '0, '0, 0, 0);
        @(posedge w_clk);
        #1 w_rst_n = 1'b0;
        w_rsp_ready = 1'b1;
        w_clear     = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(r_rsp_valid), 32'd0);
        check("midrst_busy", 32'(r_busy), 32'd1);
        repeat (2) @(posedge w_clk);
        #1 w_rst_n = 1'b1;
        idle(int'(DEPTH) + 2);
        drive(1, 0, 7'd20, '0, 1, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      ra = 7'($urandom_range(64, 127));
            else if (sel < 6) ra = 7'($urandom_range(0, 7));
            else              ra = 7'($urandom_range(0, 63));
            drive(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), ra,
                  16'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 149) == 0));
        end

        idle(int'(DEPTH) + 5);
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge w_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
